// File: rtl/intersection_pkg.sv
// Shared types and defaults for the intersection phase arbiter.
// Optional feature macro used by the top: EMERGENCY_PREEMPT_EN.
package intersection_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } phase_state_e;

    localparam int DEF_NUM_PHASES = 4;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_MIN_GREEN  = 10;
    localparam int DEF_MAX_GREEN  = 40;
    localparam int DEF_YELLOW_T   = 4;
    localparam int DEF_ALLRED_T   = 2;

    // A 2-phase junction still needs one index bit.
    function automatic int phase_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/intersection_phase_arbiter_if.sv
// Request/lamp bundle between the sensor front end (master) and the arbiter (slave).
interface intersection_phase_arbiter_if #(
    parameter int NUM_PHASES = 4,
    parameter int PW         = intersection_pkg::phase_idx_w(NUM_PHASES)
);
    logic                  tick;
    logic [NUM_PHASES-1:0] req;
    logic                  preempt_req;
    logic [PW-1:0]         preempt_phase;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] red;
    logic [PW-1:0]         active_phase;
    logic                  phase_start;

    modport master (
        output tick, req, preempt_req, preempt_phase,
        input  green, yellow, red, active_phase, phase_start
    );

    modport slave (
        input  tick, req, preempt_req, preempt_phase,
        output green, yellow, red, active_phase, phase_start
    );
endinterface

// File: rtl/intersection_rr_pick.sv
// Combinational round-robin picker: first pending phase after i_last, wrapping,
// with i_last itself considered last.
module intersection_rr_pick #(
    parameter int NUM_PHASES = 4,
    parameter int PW         = 2
) (
    input  logic [NUM_PHASES-1:0] i_pending,
    input  logic [PW-1:0]         i_last,
    output logic                  o_valid,
    output logic [PW-1:0]         o_idx
);

    // Scan from farthest to nearest so the nearest hit is the final assignment.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_last;
        for (int k = NUM_PHASES; k >= 1; k--) begin
            int j;
            j = (int'(i_last) + k) % NUM_PHASES;
            if (i_pending[j]) begin
                o_valid = 1'b1;
                o_idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Right-of-way scheduler: round-robin green with min/max green, yellow and all-red clearance.
// Define EMERGENCY_PREEMPT_EN to honour preempt_req/preempt_phase.
module intersection_phase_arbiter
    import intersection_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MIN_GREEN  = DEF_MIN_GREEN,
    parameter int MAX_GREEN  = DEF_MAX_GREEN,
    parameter int YELLOW_T   = DEF_YELLOW_T,
    parameter int ALLRED_T   = DEF_ALLRED_T
) (
    input logic                         clk,
    input logic                         reset,
    intersection_phase_arbiter_if.slave bus
);

    localparam int PW = phase_idx_w(NUM_PHASES);
    localparam logic [CNT_W-1:0] C_MIN = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] C_Y   = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] C_AR  = CNT_W'(ALLRED_T);

    phase_state_e          r_state;
    logic [CNT_W-1:0]      r_timer;
    logic [NUM_PHASES-1:0] r_pending;
    logic [PW-1:0]         r_active;
    logic                  r_grant;
    logic [NUM_PHASES-1:0] r_green;
    logic [NUM_PHASES-1:0] r_yellow;
    logic [NUM_PHASES-1:0] r_red;
    logic [PW-1:0]         r_active_q;
    logic                  r_phase_start;

    logic                  w_pre_req;
    logic [PW-1:0]         w_pre_phase;

`ifdef EMERGENCY_PREEMPT_EN
    assign w_pre_req   = bus.preempt_req;
    assign w_pre_phase = bus.preempt_phase;
`else
    logic w_unused_preempt;
    assign w_unused_preempt = bus.preempt_req ^ (^bus.preempt_phase);
    assign w_pre_req        = 1'b0;
    assign w_pre_phase      = '0;
`endif

    logic                  w_pick_valid;
    logic [PW-1:0]         w_pick_idx;

    intersection_rr_pick #(
        .NUM_PHASES (NUM_PHASES),
        .PW         (PW)
    ) u_pick (
        .i_pending (r_pending),
        .i_last    (r_active),
        .o_valid   (w_pick_valid),
        .o_idx     (w_pick_idx)
    );

    logic                  w_expired;
    logic [NUM_PHASES-1:0] w_onehot_active;
    logic                  w_other;
    logic [CNT_W-1:0]      w_elapsed;
    logic                  w_pre_hold;
    logic                  w_pre_force;
    logic                  w_rr_exit;
    logic                  w_leave_green;
    logic                  w_grant_valid;
    logic [PW-1:0]         w_grant_idx;
    logic                  w_do_grant;
    logic [NUM_PHASES-1:0] w_clr;

    assign w_expired       = (r_timer == '0);
    assign w_onehot_active = NUM_PHASES'(1) << r_active;
    assign w_other         = |(r_pending & ~w_onehot_active);
    assign w_elapsed       = C_MAX - r_timer;

    // A preempt on the current phase pins it; on any other phase it cuts green short.
    assign w_pre_hold    = w_pre_req && (r_active == w_pre_phase);
    assign w_pre_force   = w_pre_req && !w_pre_hold;
    assign w_rr_exit     = w_other && (w_elapsed >= C_MIN) && (!bus.req[r_active] || w_expired);
    assign w_leave_green = !w_pre_hold && (w_pre_force || w_rr_exit);

    assign w_grant_valid = w_pre_req || w_pick_valid;
    assign w_grant_idx   = w_pre_req ? w_pre_phase : w_pick_idx;
    assign w_do_grant    = bus.tick && (r_state == ALL_RED) && w_expired && w_grant_valid;
    assign w_clr         = w_do_grant ? (NUM_PHASES'(1) << w_grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ALL_RED;
            r_timer       <= C_AR;
            r_pending     <= '0;
            r_active      <= '0;
            r_grant       <= 1'b0;
            r_green       <= '0;
            r_yellow      <= '0;
            r_red         <= '1;
            r_active_q    <= '0;
            r_phase_start <= 1'b0;
        end else begin
            // Lamps follow the state one edge later.
            r_green       <= (r_state == GREEN)   ? w_onehot_active : '0;
            r_yellow      <= (r_state == YELLOW)  ? w_onehot_active : '0;
            r_red         <= (r_state == ALL_RED) ? '1 : ~w_onehot_active;
            r_active_q    <= r_active;
            r_phase_start <= r_grant;

            r_grant   <= 1'b0;
            r_pending <= (r_pending | bus.req) & ~w_clr;

            if (bus.tick) begin
                if (!w_expired)
                    r_timer <= r_timer - 1'b1;
                case (r_state)
                    ALL_RED: if (w_do_grant) begin
                        r_state  <= GREEN;
                        r_timer  <= C_MAX;
                        r_active <= w_grant_idx;
                        r_grant  <= 1'b1;
                    end
                    GREEN: if (w_leave_green) begin
                        r_state <= YELLOW;
                        r_timer <= C_Y;
                    end
                    YELLOW: if (w_expired) begin
                        r_state <= ALL_RED;
                        r_timer <= C_AR;
                    end
                    default: begin
                        r_state <= ALL_RED;
                        r_timer <= C_AR;
                    end
                endcase
            end
        end
    end

    assign bus.green        = r_green;
    assign bus.yellow       = r_yellow;
    assign bus.red          = r_red;
    assign bus.active_phase = r_active_q;
    assign bus.phase_start  = r_phase_start;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Bench: directed vector table, hand corner sequences, then randomized run against an elapsed-time model.
module tb_intersection_phase_arbiter;

    localparam int NP    = 4;
    localparam int MIN_G = 3;
    localparam int MAX_G = 6;
    localparam int YEL   = 2;
    localparam int AR    = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    intersection_phase_arbiter_if #(.NUM_PHASES(NP)) bus ();

    intersection_phase_arbiter #(
        .NUM_PHASES (NP),
        .CNT_W      (8),
        .MIN_GREEN  (MIN_G),
        .MAX_GREEN  (MAX_G),
        .YELLOW_T   (YEL),
        .ALLRED_T   (AR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [14:0] pack(input logic [3:0] g, input logic [3:0] y,
                                         input logic [1:0] a, input logic ps);
        return {g, y, ~(g | y), a, ps};
    endfunction

    function automatic logic [14:0] dut_out();
        return {bus.green, bus.yellow, bus.red, bus.active_phase, bus.phase_start};
    endfunction

    // Reference: mode 0=all-red,1=green,2=yellow; elapsed ticks counted upward.
    int          m_mode, m_el, m_act;
    logic [3:0]  m_pend;
    logic        m_new;
    logic [14:0] m_exp;

    task automatic model_step(input logic rst_n, input logic tk, input logic [3:0] rq);
        logic [3:0] clr, one;
        if (!rst_n) begin
            m_exp  = pack(4'b0, 4'b0, 2'd0, 1'b0);
            m_mode = 0; m_el = 0; m_act = 0; m_pend = '0; m_new = 1'b0;
            return;
        end
        one   = 4'b0001 << m_act;
        m_exp = pack((m_mode == 1) ? one : 4'b0, (m_mode == 2) ? one : 4'b0, 2'(m_act), m_new);
        m_new = 1'b0;
        clr   = '0;
        if (tk) begin
            if (m_mode == 0) begin
                if (m_el >= AR && m_pend != 0) begin
                    int idx;
                    idx = -1;
                    for (int k = 1; k <= NP; k++)
                        if (idx < 0 && m_pend[(m_act + k) % NP]) idx = (m_act + k) % NP;
                    m_mode = 1; m_act = idx; m_el = 0; m_new = 1'b1;
                    clr = 4'b0001 << idx;
                end else m_el++;
            end else if (m_mode == 1) begin
                if ((m_pend & ~one) != 0 && m_el >= MIN_G && (!rq[m_act] || m_el >= MAX_G)) begin
                    m_mode = 2; m_el = 0;
                end else m_el++;
            end else begin
                if (m_el >= YEL) begin m_mode = 0; m_el = 0; end
                else m_el++;
            end
            if (m_el > 1000) m_el = 1000;
        end
        m_pend = (m_pend | rq) & ~clr;
    endtask

    bit chk_model = 0;

    task automatic step(input logic rst_n, input logic tk, input logic [3:0] rq);
        reset   = rst_n;
        bus.tick = tk;
        bus.req  = rq;
        model_step(rst_n, tk, rq);
        @(posedge clk);
        #1;
        if (chk_model) check("model", 32'(dut_out()), 32'(m_exp));
    endtask

    task automatic wait_grant(input string name, input int exp_phase, input logic [3:0] rq);
        bit found;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            step(1'b1, 1'b1, rq);
            if (bus.phase_start === 1'b1) found = 1;
        end
        check(name, found ? 32'(bus.active_phase) : 32'hdead, 32'(exp_phase));
    endtask

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [3:0]  g;
        logic [3:0]  y;
        logic [1:0]  a;
        logic        ps;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                                input logic [3:0] y, input logic [1:0] a, input logic ps);
        vec_t v;
        v.rst_n = r; v.req = q; v.g = g; v.y = y; v.a = a; v.ps = ps;
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        bit ok;
        reset             = 1'b0;
        bus.tick          = 1'b0;
        bus.req           = '0;
        bus.preempt_req   = 1'b0;
        bus.preempt_phase = '0;

        // Grant of phase 2, max-green exit with phase 0 waiting, then min-green exit of phase 0.
        tbl[0]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        tbl[1]  = mk(1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0);
        tbl[2]  = mk(1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0);
        tbl[3]  = mk(1, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1);
        tbl[4]  = mk(1, 4'b0101, 4'b0100, 4'b0000, 2'd2, 0);
        for (int k = 5; k <= 9; k++)   tbl[k] = mk(1, 4'b0100, 4'b0100, 4'b0000, 2'd2, 0);
        for (int k = 10; k <= 12; k++) tbl[k] = mk(1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
        tbl[13] = mk(1, 4'b0100, 4'b0000, 4'b0000, 2'd2, 0);
        tbl[14] = mk(1, 4'b0100, 4'b0000, 4'b0000, 2'd2, 0);
        tbl[15] = mk(1, 4'b0100, 4'b0001, 4'b0000, 2'd0, 1);
        for (int k = 16; k <= 18; k++) tbl[k] = mk(1, 4'b0100, 4'b0001, 4'b0000, 2'd0, 0);
        tbl[19] = mk(1, 4'b0100, 4'b0000, 4'b0001, 2'd0, 0);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rst_n, 1'b1, tbl[i].req);
            check($sformatf("vec%0d", i), 32'(dut_out()),
                  32'(pack(tbl[i].g, tbl[i].y, tbl[i].a, tbl[i].ps)));
        end

        // Reset while phase 0 is in yellow, then no requests: pending must be gone.
        step(1'b0, 1'b1, 4'b0000);
        check("reset_mid_yellow", 32'(dut_out()), 32'(pack(4'b0, 4'b0, 2'd0, 1'b0)));
        ok = 1;
        for (int c = 0; c < 15; c++) begin
            step(1'b1, 1'b1, 4'b0000);
            if (bus.red !== 4'b1111 || bus.green !== 4'b0000 || bus.phase_start !== 1'b0) ok = 0;
        end
        check("idle_all_red", 32'(ok), 32'd1);

        // Min-green: phase 2 drops its request, phase 3 arrives right after green starts.
        wait_grant("grant_p2", 2, 4'b0100);
        step(1'b1, 1'b1, 4'b1000);
        check("min_g1", 32'(bus.green), 32'h4);
        step(1'b1, 1'b1, 4'b0000);
        check("min_g2", 32'(bus.green), 32'h4);
        step(1'b1, 1'b1, 4'b0000);
        check("min_g3", 32'(bus.green), 32'h4);
        step(1'b1, 1'b1, 4'b0000);
        check("min_yellow", 32'({bus.green, bus.yellow}), 32'h04);

        // Round-robin from active 1 with pending 1011: expect 3, 0, 1.
        step(1'b0, 1'b1, 4'b0000);
        wait_grant("grant_p1", 1, 4'b0010);
        step(1'b1, 1'b1, 4'b1011);
        wait_grant("rr_first", 3, 4'b0000);
        wait_grant("rr_second", 0, 4'b0000);
        wait_grant("rr_third", 1, 4'b0000);

        // Randomized run; preempt inputs toggle but must have no effect.
        chk_model = 1;
        step(1'b0, 1'b1, 4'b0000);
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] rq;
            rq = 4'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) rq = rq | bus.req;
            bus.preempt_req   = 1'($urandom);
            bus.preempt_phase = 2'($urandom);
            step($urandom_range(0, 399) != 0, $urandom_range(0, 3) != 0, rq);
        end
        chk_model = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
